// File: rtl/temp_bcd_fmt.sv
// temp_bcd_fmt
//   Turns the DS18B20 driver's scaled temperature word (|degC| x 10000) into
//   display-ready BCD digits for the 7-segment scan logic. The conversion is a
//   sequential shift-add-3 (double-dabble) engine that consumes one binary bit
//   per clock, so a sample takes IN_W clocks in CONV plus one OUT cycle.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   temp_sign       sample sign (1 = negative), qualified by temp_vld
//   temp_val        |temperature| x 10000, qualified by temp_vld
//   temp_vld        one-cycle strobe announcing a new sample
//   busy            high while a conversion is running (CONV or OUT)
//   dig_sign        show a minus sign (never for a zero value)
//   dig_hun/ten     hundreds/tens digit, 4'hF = blank
//   dig_one         units digit, never blank
//   dig_f1/f2       tenths/hundredths digit (truncated)
//   ovf             integer part above 999; digits clamped to 9s
//   disp_vld        one-cycle strobe, digit outputs just updated
//   dbg_state_o     current FSM state for observation
//
// Handshake: temp_vld is a fire-and-forget strobe with no ready. A sample that
// arrives while busy is held in a one-deep pending slot (newest wins) and is
// started as soon as the running conversion finishes; a live strobe in the OUT
// cycle takes priority over the pending slot. disp_vld is likewise a strobe;
// the digit outputs hold their value until the next disp_vld.

module temp_bcd_fmt #(
    parameter int IN_W     = 24,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            temp_sign,
    input  logic [IN_W-1:0] temp_val,
    input  logic            temp_vld,
    output logic            busy,
    output logic            dig_sign,
    output logic [3:0]      dig_hun,
    output logic [3:0]      dig_ten,
    output logic [3:0]      dig_one,
    output logic [3:0]      dig_f1,
    output logic [3:0]      dig_f2,
    output logic            ovf,
    output logic            disp_vld,
    output logic [1:0]      dbg_state_o
);

    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   bin_q, bin_d;
    logic [31:0]       bcd_q, bcd_d;
    logic              sgn_q, sgn_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [IN_W-1:0]   pend_val_q, pend_val_d;
    logic              pend_sgn_q, pend_sgn_d;

    logic              dig_sign_q, dig_sign_d;
    logic [3:0]        dig_hun_q, dig_hun_d;
    logic [3:0]        dig_ten_q, dig_ten_d;
    logic [3:0]        dig_one_q, dig_one_d;
    logic [3:0]        dig_f1_q, dig_f1_d;
    logic [3:0]        dig_f2_q, dig_f2_d;
    logic              ovf_q, ovf_d;
    logic              disp_vld_q, disp_vld_d;

    // Add-3 correction on every BCD nibble before the shift.
    logic [31:0]       bcd_adj;
    logic [31+IN_W:0]  shifted;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Formatting of the finished BCD word; only consumed in the OUT cycle.
    logic [3:0] d7, d6, d5, d4, d3, d2;
    logic       fmt_ovf;
    logic       fmt_sign;
    logic [3:0] fmt_hun, fmt_ten, fmt_one, fmt_f1, fmt_f2;

    always_comb begin
        d7       = bcd_q[31:28];
        d6       = bcd_q[27:24];
        d5       = bcd_q[23:20];
        d4       = bcd_q[19:16];
        d3       = bcd_q[15:12];
        d2       = bcd_q[11:8];
        fmt_ovf  = (d7 != 4'd0);
        // A negative zero is shown as plain zero.
        fmt_sign = sgn_q && (bcd_q != 32'd0);
        fmt_hun  = d6;
        fmt_ten  = d5;
        fmt_one  = d4;
        fmt_f1   = d3;
        fmt_f2   = d2;
        if (fmt_ovf) begin
            fmt_hun = 4'd9;
            fmt_ten = 4'd9;
            fmt_one = 4'd9;
            fmt_f1  = 4'd9;
            fmt_f2  = 4'd9;
        end else if (BLANK_LZ) begin
            if (d6 == 4'd0) begin
                fmt_hun = 4'hF;
                if (d5 == 4'd0) begin
                    fmt_ten = 4'hF;
                end
            end
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        sgn_d      = sgn_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        pend_sgn_d = pend_sgn_q;
        dig_sign_d = dig_sign_q;
        dig_hun_d  = dig_hun_q;
        dig_ten_d  = dig_ten_q;
        dig_one_d  = dig_one_q;
        dig_f1_d   = dig_f1_q;
        dig_f2_d   = dig_f2_q;
        ovf_d      = ovf_q;
        disp_vld_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (temp_vld) begin
                    bin_d   = temp_val;
                    bcd_d   = 32'd0;
                    sgn_d   = temp_sign;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (temp_vld) begin
                    pend_d     = 1'b1;
                    pend_val_d = temp_val;
                    pend_sgn_d = temp_sign;
                end
                bcd_d = shifted[31+IN_W:IN_W];
                bin_d = shifted[IN_W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                dig_sign_d = fmt_sign;
                dig_hun_d  = fmt_hun;
                dig_ten_d  = fmt_ten;
                dig_one_d  = fmt_one;
                dig_f1_d   = fmt_f1;
                dig_f2_d   = fmt_f2;
                ovf_d      = fmt_ovf;
                disp_vld_d = 1'b1;
                cnt_d      = '0;
                bcd_d      = 32'd0;
                pend_d     = 1'b0;
                if (temp_vld) begin
                    // Live sample is newer than anything pending.
                    bin_d   = temp_val;
                    sgn_d   = temp_sign;
                    state_d = S_CONV;
                end else if (pend_q) begin
                    bin_d   = pend_val_q;
                    sgn_d   = pend_sgn_q;
                    state_d = S_CONV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= 32'd0;
            sgn_q      <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            pend_sgn_q <= 1'b0;
            dig_sign_q <= 1'b0;
            dig_hun_q  <= 4'h0;
            dig_ten_q  <= 4'h0;
            dig_one_q  <= 4'h0;
            dig_f1_q   <= 4'h0;
            dig_f2_q   <= 4'h0;
            ovf_q      <= 1'b0;
            disp_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            sgn_q      <= sgn_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            pend_sgn_q <= pend_sgn_d;
            dig_sign_q <= dig_sign_d;
            dig_hun_q  <= dig_hun_d;
            dig_ten_q  <= dig_ten_d;
            dig_one_q  <= dig_one_d;
            dig_f1_q   <= dig_f1_d;
            dig_f2_q   <= dig_f2_d;
            ovf_q      <= ovf_d;
            disp_vld_q <= disp_vld_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign dig_sign    = dig_sign_q;
    assign dig_hun     = dig_hun_q;
    assign dig_ten     = dig_ten_q;
    assign dig_one     = dig_one_q;
    assign dig_f1      = dig_f1_q;
    assign dig_f2      = dig_f2_q;
    assign ovf         = ovf_q;
    assign disp_vld    = disp_vld_q;
    assign dbg_state_o = state_q;

endmodule
